// File: rtl/axi4_lite_master_pkg.sv
// Shared AXI4-Lite types: response codes and the master FSM state encoding.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        S_IDLE            = 3'd0,
        S_WRITE_ADDR_DATA = 3'd1,
        S_WRITE_RESP      = 3'd2,
        S_READ_ADDR       = 3'd3,
        S_READ_DATA       = 3'd4,
        S_RESPOND         = 3'd5
    } mst_state_t;

endpackage

// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction out,
// one response back. All outputs come straight from registers.
//
//   state             | meaning
//   ------------------+-----------------------------------------------
//   S_IDLE            | cmd_ready high, waiting for a command
//   S_WRITE_ADDR_DATA | AW and W offered together, each drops on its own handshake
//   S_WRITE_RESP      | BREADY high, waiting for BVALID
//   S_READ_ADDR       | ARVALID high, waiting for ARREADY
//   S_READ_DATA       | RREADY high, waiting for RVALID
//   S_RESPOND         | rsp_valid high, holding response until rsp_ready
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESET_N,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    axi4_lite_if.master             axi
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    mst_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    resp_t                 rsp_resp_q, rsp_resp_d;

    logic aw_hs, w_hs;

    assign aw_hs = awvalid_q && axi.AWREADY;
    assign w_hs  = wvalid_q && axi.WREADY;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d = cmd_addr;
                    if (cmd_write) begin
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = S_WRITE_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_READ_ADDR;
                    end
                end
            end
            S_WRITE_ADDR_DATA: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Both channels may finish in the same cycle or in either order.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = S_WRITE_RESP;
                end
            end
            S_WRITE_RESP: begin
                if (axi.BVALID) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = resp_t'(axi.BRESP);
                    state_d     = S_RESPOND;
                end
            end
            S_READ_ADDR: begin
                if (axi.ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_READ_DATA;
                end
            end
            S_READ_DATA: begin
                if (axi.RVALID) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = axi.RDATA;
                    rsp_resp_d  = resp_t'(axi.RRESP);
                    state_d     = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESET_N) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= OKAY;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;

    assign axi.AWADDR  = addr_q;
    assign axi.AWVALID = awvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.BREADY  = bready_q;
    assign axi.ARADDR  = addr_q;
    assign axi.ARVALID = arvalid_q;
    assign axi.RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master; the bench itself plays the AXI4-Lite slave.
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          ACLK = 1'b0;
    logic          ARESET_N;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW/8-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;

    int total = 0;
    int bad   = 0;

    axi4_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi4_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK      (ACLK),
        .ARESET_N  (ARESET_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .axi       (axi)
    );

    always #5 ACLK = ~ACLK;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        ARESET_N = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        axi.BVALID = 1'b0; axi.BRESP = 2'b00;
        axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RDATA = '0; axi.RRESP = 2'b00;

        // Reset values
        step(); step();
        chk("rst_cmd_ready", 64'(cmd_ready), 0);
        chk("rst_awvalid", 64'(axi.AWVALID), 0);
        chk("rst_wvalid", 64'(axi.WVALID), 0);
        chk("rst_bready", 64'(axi.BREADY), 0);
        chk("rst_arvalid", 64'(axi.ARVALID), 0);
        chk("rst_rready", 64'(axi.RREADY), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_awaddr", 64'(axi.AWADDR), 0);
        chk("rst_wdata", 64'(axi.WDATA), 0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 0);
        ARESET_N = 1'b1;
        step();
        chk("idle_cmd_ready", 64'(cmd_ready), 1);

        // Write to an always-ready slave
        axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
        send_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
        chk("w1_awvalid", 64'(axi.AWVALID), 1);
        chk("w1_wvalid", 64'(axi.WVALID), 1);
        chk("w1_awaddr", 64'(axi.AWADDR), 64'h4);
        chk("w1_wdata", 64'(axi.WDATA), 64'hDEADBEEF);
        chk("w1_wstrb", 64'(axi.WSTRB), 64'hF);
        chk("w1_cmd_ready", 64'(cmd_ready), 0);
        step();
        chk("w1_awvalid_drop", 64'(axi.AWVALID), 0);
        chk("w1_wvalid_drop", 64'(axi.WVALID), 0);
        chk("w1_bready", 64'(axi.BREADY), 1);
        step();
        chk("w1_bready_wait", 64'(axi.BREADY), 1);
        chk("w1_no_rsp", 64'(rsp_valid), 0);
        axi.BVALID = 1'b1; axi.BRESP = 2'b00;
        step();
        axi.BVALID = 1'b0;
        chk("w1_bready_off", 64'(axi.BREADY), 0);
        chk("w1_rsp_valid", 64'(rsp_valid), 1);
        chk("w1_rsp_write", 64'(rsp_write), 1);
        chk("w1_rsp_resp", 64'(rsp_resp), 0);
        chk("w1_rsp_rdata", 64'(rsp_rdata), 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("w1_rsp_done", 64'(rsp_valid), 0);
        chk("w1_back_idle", 64'(cmd_ready), 1);

        // Skewed write: W completes three cycles before AW
        axi.AWREADY = 1'b0; axi.WREADY = 1'b1;
        send_cmd(1'b1, 4'h8, 32'hA5A5A5A5, 4'h3);
        chk("w2_both_valid", 64'({axi.AWVALID, axi.WVALID}), 64'b11);
        step();
        axi.WREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("w2_wvalid_low", 64'(axi.WVALID), 0);
            chk("w2_awvalid_held", 64'(axi.AWVALID), 1);
            chk("w2_awaddr_stable", 64'(axi.AWADDR), 64'h8);
            chk("w2_bready_low", 64'(axi.BREADY), 0);
            if (i < 2) step();
        end
        axi.AWREADY = 1'b1;
        step();
        axi.AWREADY = 1'b0;
        chk("w2_awvalid_drop", 64'(axi.AWVALID), 0);
        chk("w2_bready", 64'(axi.BREADY), 1);
        axi.BVALID = 1'b1; axi.BRESP = 2'b00;
        step();
        axi.BVALID = 1'b0;
        chk("w2_rsp_valid", 64'(rsp_valid), 1);

        // Backpressure on the response, with a pending command waiting
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h2;
        axi.AWREADY = 1'b1; axi.WREADY = 1'b1; axi.ARREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_rsp_valid", 64'(rsp_valid), 1);
            chk("bp_rsp_fields", 64'({rsp_write, rsp_resp, rsp_rdata}), {31'd0, 1'b1, 2'b00, 32'd0});
            chk("bp_cmd_ready", 64'(cmd_ready), 0);
            chk("bp_no_valids", 64'({axi.AWVALID, axi.WVALID, axi.ARVALID}), 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_released", 64'({rsp_valid, cmd_ready}), 64'b01);

        // Read with two cycles of RVALID delay
        send_cmd(1'b0, 4'hC, 32'h0, 4'h0);
        chk("r1_arvalid", 64'(axi.ARVALID), 1);
        chk("r1_araddr", 64'(axi.ARADDR), 64'hC);
        chk("r1_rready_low", 64'(axi.RREADY), 0);
        step();
        chk("r1_arvalid_drop", 64'(axi.ARVALID), 0);
        chk("r1_rready", 64'(axi.RREADY), 1);
        step();
        chk("r1_rready_wait1", 64'(axi.RREADY), 1);
        step();
        chk("r1_rready_wait2", 64'(axi.RREADY), 1);
        chk("r1_no_rsp", 64'(rsp_valid), 0);
        axi.RVALID = 1'b1; axi.RDATA = 32'h12345678; axi.RRESP = 2'b00;
        step();
        axi.RVALID = 1'b0;
        chk("r1_rready_off", 64'(axi.RREADY), 0);
        chk("r1_rsp_valid", 64'(rsp_valid), 1);
        chk("r1_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
        chk("r1_rsp_resp", 64'(rsp_resp), 0);
        chk("r1_rsp_write", 64'(rsp_write), 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Error pass-through on read, then a normal write
        send_cmd(1'b0, 4'h0, 32'h0, 4'h0);
        step();
        axi.RVALID = 1'b1; axi.RDATA = 32'hCAFEF00D; axi.RRESP = 2'b10;
        step();
        axi.RVALID = 1'b0; axi.RRESP = 2'b00;
        chk("err_rsp_resp", 64'(rsp_resp), 64'b10);
        chk("err_rsp_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("err_idle", 64'(cmd_ready), 1);
        send_cmd(1'b1, 4'h4, 32'h11223344, 4'h5);
        chk("err_w_wdata", 64'(axi.WDATA), 64'h11223344);
        step();
        axi.BVALID = 1'b1; axi.BRESP = 2'b00;
        step();
        axi.BVALID = 1'b0;
        chk("err_w_rsp", 64'({rsp_valid, rsp_write, rsp_resp}), 64'b1100);
        chk("err_w_rdata", 64'(rsp_rdata), 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset while waiting in WRITE_RESP
        send_cmd(1'b1, 4'h6, 32'h55AA55AA, 4'hF);
        step();
        chk("mr_bready", 64'(axi.BREADY), 1);
        ARESET_N = 1'b0;
        step();
        chk("mr_bready_rst", 64'(axi.BREADY), 0);
        chk("mr_valids_rst", 64'({axi.AWVALID, axi.WVALID, axi.ARVALID, axi.RREADY}), 0);
        chk("mr_awaddr_rst", 64'(axi.AWADDR), 0);
        chk("mr_wdata_rst", 64'(axi.WDATA), 0);
        chk("mr_wstrb_rst", 64'(axi.WSTRB), 0);
        chk("mr_rsp_rst", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}), 0);
        chk("mr_cmd_ready_rst", 64'(cmd_ready), 0);
        ARESET_N = 1'b1;
        axi.BVALID = 1'b1;
        step();
        axi.BVALID = 1'b0;
        chk("mr_cmd_ready", 64'(cmd_ready), 1);
        chk("mr_no_rsp", 64'(rsp_valid), 0);
        step();
        chk("mr_still_no_rsp", 64'({rsp_valid, axi.BREADY}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master.md
# axi4_lite_master

AXI4-Lite initiator that turns a simple single-outstanding command/response interface into AXI4-Lite write and read transactions. It sits between an internal controller (sequencer, debug bridge or test driver) and any AXI4-Lite slave in the design, for example the GPIO/PWM register slave. It issues exactly one transaction at a time, drives AW and W together, and tolerates either handshake completing first. It returns read data and the BRESP or RRESP to the requester.

## Interface
Parameters:
- ADDR_WIDTH, 4, byte address width of AWADDR/ARADDR and cmd_addr
- DATA_WIDTH, 32, data width; a multiple of 8; strobe width is DATA_WIDTH/8

Ports:
- ACLK  in  1  clock; all logic on its rising edge
- ARESET_N  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  requester consumes response
- rsp_write  out  1  echoes cmd_write of the completed transaction
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP of the completed transaction
- AWADDR/AWVALID out, AWREADY in; WDATA/WSTRB/WVALID out, WREADY in; BRESP/BVALID in, BREADY out; ARADDR/ARVALID out, ARREADY in; RDATA/RRESP/RVALID in, RREADY out. These are standard AXI4-Lite, with widths per the parameters.

## Operation
- FSM states: IDLE, WRITE_ADDR_DATA, WRITE_RESP, READ_ADDR, READ_DATA, RESPOND.
- IDLE: cmd_ready=1. On a command handshake, latch addr/wdata/wstrb/write into registers, then go to WRITE_ADDR_DATA (write) or READ_ADDR (read).
- WRITE_ADDR_DATA: AWVALID and WVALID start at 1.
  - Per-channel done flags aw_done and w_done.
  - AWVALID drops the cycle after the AW handshake, and WVALID the cycle after the W handshake.
  - Once both flags are set (same or different cycles), go to WRITE_RESP.
- WRITE_RESP: BREADY=1. On BVALID, capture BRESP, set rsp_write=1 and rsp_rdata=0, then go to RESPOND.
- READ_ADDR: ARVALID=1 until the AR handshake, then go to READ_DATA.
- READ_DATA: RREADY=1. On RVALID, capture RDATA/RRESP and rsp_write=0, then go to RESPOND.
- RESPOND: rsp_valid=1 and the response fields are held stable. On rsp_ready, go to IDLE.
- VALID stability: once asserted, AWVALID/WVALID/ARVALID and their payloads stay constant until their handshake. Command inputs are never forwarded combinationally.
- A non-OKAY response (SLVERR/DECERR) is passed through unchanged; there is no retry.
- Reset: synchronous, active-low, can occur in any state. It aborts any transaction in flight and returns the block to IDLE with no response generated.

## Timing
- Reset values: cmd_ready=0 while ARESET_N=0 and 1 on the first cycle in IDLE. AWVALID, WVALID, BREADY, ARVALID, RREADY and rsp_valid are 0. AWADDR, WDATA, WSTRB, ARADDR, rsp_rdata and rsp_resp are 0; rsp_write=0.
- Every AXI-side output and every rsp_* output is registered; there are no combinational paths from inputs to outputs.
- AXI valids (AWVALID/WVALID/ARVALID) rise the cycle after the command handshake.
- BREADY and RREADY are high from the cycle after the last address/data handshake until the response handshake, inclusive. They are 0 in all other states.
- rsp_valid rises the cycle after the B or R handshake.
- IDLE is re-entered the cycle after the rsp handshake, so back-to-back commands are accepted every (transaction + 1) cycles at minimum.
- Write latency with an always-ready slave that has 1-cycle BVALID:
  - cycle 0: command accepted
  - cycle 1: AW/W handshake
  - cycle 2: BREADY high
  - B handshake when the slave asserts BVALID
  - rsp_valid on the next cycle
- Read latency with an always-ready slave: command at cycle 0, AR handshake at 1, R handshake at 2 or later, rsp_valid one cycle after the R handshake.

## Structure
- A shared package axi4_lite_pkg holds:
  - the resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - the master FSM state enum
- No sub-module is needed: a single FSM with a command holding register.

## Test plan
- Write to an always-ready slave: cmd addr=0x4, wdata=0xDEADBEEF, wstrb=0xF. The AW/W handshake occurs one cycle after the command; the bench drives BVALID two cycles later. Required: rsp_valid with rsp_resp=00, rsp_write=1.
- Skewed write: WREADY is high 3 cycles before AWREADY. Required: WVALID drops after the W handshake, AWVALID is held with addr 0x8 stable, and BREADY rises only after the AW handshake.
- Read: cmd addr=0xC, slave returns RDATA=0x12345678 with 2 cycles of RVALID delay. Required: RREADY is held high while waiting, then rsp_rdata=0x12345678, rsp_resp=00.
- Error pass-through: the slave returns RRESP=2'b10 on a read. Required: rsp_resp=10. A following write accepted in IDLE completes normally.
- Backpressure: rsp_ready=0 for 4 cycles. Required: rsp_valid and rsp_* are stable, cmd_ready=0, and no new AXI valids are raised.
- Mid-transaction reset: ARESET_N=0 for 1 cycle while in WRITE_RESP. Required: all outputs at their reset values the next cycle, no rsp_valid, and cmd_ready=1 after reset is released.
